// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller.
// Holds the operand/tag widths, the one-hot ALU op bit positions, the mask of
// multi-cycle ops and the controller state encoding.
package alu_issue_ctrl_pkg;

  localparam int unsigned ALU_OP_W = 19;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned TAG_W    = 5;

  // Bit position of each operation inside the one-hot op vector.
  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_SUB   = 1;
  localparam int unsigned OP_AND   = 2;
  localparam int unsigned OP_OR    = 3;
  localparam int unsigned OP_XOR   = 4;
  localparam int unsigned OP_SLL   = 5;
  localparam int unsigned OP_SRL   = 6;
  localparam int unsigned OP_SRA   = 7;
  localparam int unsigned OP_SLT   = 8;
  localparam int unsigned OP_SLTU  = 9;
  localparam int unsigned OP_LUI   = 10;
  localparam int unsigned OP_AUIPC = 11;
  localparam int unsigned OP_MUL   = 12;
  localparam int unsigned OP_MULH  = 13;
  localparam int unsigned OP_MULHU = 14;
  localparam int unsigned OP_DIV   = 15;
  localparam int unsigned OP_DIVU  = 16;
  localparam int unsigned OP_MOD   = 17;
  localparam int unsigned OP_MODU  = 18;

  // Multiply/divide family: ops 18..12 may take more than one cycle.
  localparam logic [ALU_OP_W-1:0] MULTI_OP_MASK = 19'h7F000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/alu_issue_perf.sv
// Performance counters for the ALU issue controller.
// Ports: clk/resetn (sync active-low), retire (one op retired this cycle),
// stall (waiting on the ALU this cycle), perf_ops/perf_stall (wrapping counts).
module alu_issue_perf
  import alu_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              retire,
  input  logic              stall,
  output logic [DATA_W-1:0] perf_ops,
  output logic [DATA_W-1:0] perf_stall
);

  logic [DATA_W-1:0] ops_q, ops_d;
  logic [DATA_W-1:0] stall_q, stall_d;

  // Free-running counters; overflow simply wraps.
  always_comb begin
    ops_d   = ops_q + DATA_W'(retire);
    stall_d = stall_q + DATA_W'(stall);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      ops_q   <= ops_d;
      stall_q <= stall_d;
    end
  end

  assign perf_ops   = ops_q;
  assign perf_stall = stall_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one op at a time from decode, holds it on the
// ALU until alu_complete, forwards the result downstream, and buffers it when
// downstream is not ready. Flush discards the op; a flushed op whose ALU work
// is still running is drained so a multi-cycle unit is never abandoned.
// Ports: clk/resetn (sync active-low); id_* upstream handshake and payload;
// alu_* ALU drive and response; exe_*/mem_ready downstream handshake;
// flush; perf_ops/perf_stall counters.
// Build option: define ALU_ISSUE_PERF_EN to enable the performance counters;
// otherwise both perf outputs are tied to zero.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic [DATA_W-1:0]   id_src1,
  input  logic [DATA_W-1:0]   id_src2,
  input  logic [TAG_W-1:0]    id_tag,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [DATA_W-1:0]   alu_src1,
  output logic [DATA_W-1:0]   alu_src2,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_complete,
  output logic                exe_valid,
  output logic [DATA_W-1:0]   exe_result,
  output logic [TAG_W-1:0]    exe_tag,
  input  logic                mem_ready,
  input  logic                flush,
  output logic [DATA_W-1:0]   perf_ops,
  output logic [DATA_W-1:0]   perf_stall
);

  state_e              state_q, state_d;
  logic [ALU_OP_W-1:0] op_q, op_d;
  logic [DATA_W-1:0]   src1_q, src1_d;
  logic [DATA_W-1:0]   src2_q, src2_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic idle_c, busy_c, hold_c, drain_c, transfer_c;

  assign idle_c  = (state_q == ST_IDLE);
  assign busy_c  = (state_q == ST_BUSY);
  assign hold_c  = (state_q == ST_HOLD);
  assign drain_c = (state_q == ST_DRAIN);

  // Ready when the slot is empty or the current op retires this cycle.
  assign id_ready   = ~flush & (idle_c | (busy_c & alu_complete & mem_ready) |
                                (hold_c & mem_ready));
  assign transfer_c = id_valid & id_ready;

  // Next-state and payload capture.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    tag_d    = tag_q;
    result_d = result_q;

    // A transfer only happens once the previous op has left, so the tag of an
    // in-flight op is never overwritten.
    if (transfer_c) begin
      op_d   = id_alu_op;
      src1_d = id_src1;
      src2_d = id_src2;
      tag_d  = id_tag;
    end

    case (state_q)
      ST_IDLE: begin
        if (transfer_c) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = alu_complete ? ST_IDLE : ST_DRAIN;
        end else if (alu_complete) begin
          if (mem_ready) begin
            state_d = transfer_c ? ST_BUSY : ST_IDLE;
          end else begin
            state_d  = ST_HOLD;
            result_d = alu_result;
          end
        end
      end
      ST_HOLD: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mem_ready) begin
          state_d = transfer_c ? ST_BUSY : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // Flush is ignored here; wait for the ALU to finish.
        if (alu_complete) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      tag_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      tag_q    <= tag_d;
      result_q <= result_d;
    end
  end

  assign alu_op     = (busy_c | drain_c) ? op_q : '0;
  assign alu_src1   = src1_q;
  assign alu_src2   = src2_q;
  // In BUSY the ALU result passes straight through; HOLD replays the capture.
  assign exe_valid  = ~flush & ((busy_c & alu_complete) | hold_c);
  assign exe_result = busy_c ? alu_result : result_q;
  assign exe_tag    = tag_q;

`ifdef ALU_ISSUE_PERF_EN
  logic retire_c, stall_c;

  assign retire_c = exe_valid & mem_ready;
  assign stall_c  = (busy_c | drain_c) & ~alu_complete;

  alu_issue_perf u_perf (
    .clk        (clk),
    .resetn     (resetn),
    .retire     (retire_c),
    .stall      (stall_c),
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
  );
`else
  assign perf_ops   = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios followed by a
// randomized run, all compared each cycle against a transaction-level model.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

`ifdef ALU_ISSUE_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                resetn;
  logic                id_valid;
  logic                id_ready;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic [DATA_W-1:0]   id_src1, id_src2;
  logic [TAG_W-1:0]    id_tag;
  logic [ALU_OP_W-1:0] alu_op;
  logic [DATA_W-1:0]   alu_src1, alu_src2;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_complete;
  logic                exe_valid;
  logic [DATA_W-1:0]   exe_result;
  logic [TAG_W-1:0]    exe_tag;
  logic                mem_ready;
  logic                flush;
  logic [DATA_W-1:0]   perf_ops, perf_stall;
  logic                lat_bit;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .resetn(resetn),
    .id_valid(id_valid), .id_ready(id_ready), .id_alu_op(id_alu_op),
    .id_src1(id_src1), .id_src2(id_src2), .id_tag(id_tag),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result), .alu_complete(alu_complete),
    .exe_valid(exe_valid), .exe_result(exe_result), .exe_tag(exe_tag),
    .mem_ready(mem_ready), .flush(flush),
    .perf_ops(perf_ops), .perf_stall(perf_stall)
  );

  // Reference arithmetic for every one-hot op.
  function automatic logic [31:0] golden(input logic [18:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    int idx;
    logic [63:0] ps, pu;
    idx = -1;
    for (int k = 0; k < 19; k++) if (op == (19'(1) << k)) idx = k;
    ps = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    pu = {32'b0, a} * {32'b0, b};
    case (idx)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << b[4:0];
      6:  return a >> b[4:0];
      7:  return 32'($signed(a) >>> b[4:0]);
      8:  return {31'b0, ($signed(a) < $signed(b))};
      9:  return {31'b0, (a < b)};
      10: return b;
      11: return a + (b << 12);
      12: return a * b;
      13: return ps[63:32];
      14: return pu[63:32];
      15: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      16: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      17: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      18: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // ALU stand-in: single-cycle ops complete at once, multi-cycle ops on lat_bit.
  assign alu_complete = ((alu_op & MULTI_OP_MASK) == '0) | lat_bit;
  assign alu_result   = golden(alu_op, alu_src1, alu_src2);

  typedef struct {
    logic [18:0] op;
    logic [31:0] res;
    logic [4:0]  tag;
  } txn_t;

  txn_t        q[$];
  bit          held, draining;
  logic [18:0] drain_op;
  logic [31:0] last_s1, last_s2;
  int unsigned m_ops, m_stall;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] perf_exp(input int unsigned n);
    return PERF_ON ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare DUT against the model mid-cycle, then advance the model.
  task automatic sample();
    bit          exec, vld, rdy;
    logic [18:0] exp_op;
    @(negedge clk);
    if (!resetn) begin
      q.delete(); held = 0; draining = 0;
      last_s1 = '0; last_s2 = '0; m_ops = 0; m_stall = 0;
      return;
    end
    chk("perf_ops", perf_ops, perf_exp(m_ops));
    chk("perf_stall", perf_stall, perf_exp(m_stall));
    exec   = (q.size() != 0) && !held;
    exp_op = draining ? drain_op : (exec ? q[0].op : '0);
    chk("alu_op", 32'(alu_op), 32'(exp_op));
    chk("alu_src1", alu_src1, last_s1);
    chk("alu_src2", alu_src2, last_s2);
    if (draining || flush)  begin vld = 0; rdy = 0; end
    else if (q.size() == 0) begin vld = 0; rdy = 1; end
    else begin
      vld = held | alu_complete;
      rdy = vld & mem_ready;
    end
    chk("exe_valid", 32'(exe_valid), 32'(vld));
    chk("id_ready", 32'(id_ready), 32'(rdy));
    if (vld) begin
      chk("exe_result", exe_result, q[0].res);
      chk("exe_tag", 32'(exe_tag), 32'(q[0].tag));
    end
    if ((exec || draining) && !alu_complete) m_stall++;
    if (draining) begin
      if (alu_complete) draining = 0;
    end else if (flush) begin
      if (exec && !alu_complete) begin draining = 1; drain_op = q[0].op; end
      q.delete(); held = 0;
    end else begin
      if (q.size() != 0) begin
        if (vld && mem_ready) begin void'(q.pop_front()); held = 0; m_ops++; end
        else if (vld) held = 1;
      end
      if (rdy && id_valid) begin
        q.push_back('{op: id_alu_op, res: golden(id_alu_op, id_src1, id_src2), tag: id_tag});
        last_s1 = id_src1; last_s2 = id_src2;
      end
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int unsigned idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t);
    id_valid = 1'b1; id_alu_op = ALU_OP_W'(1) << idx;
    id_src1 = a; id_src2 = b; id_tag = t;
  endtask

  task automatic do_reset();
    resetn = 1'b0; id_valid = 1'b0; flush = 1'b0;
    sample(); nxt();
    resetn = 1'b1;
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_alu_op"}, 32'(alu_op), 32'd0);
    chk({p, "_src1"}, alu_src1, 32'd0);
    chk({p, "_src2"}, alu_src2, 32'd0);
    chk({p, "_valid"}, 32'(exe_valid), 32'd0);
    chk({p, "_result"}, exe_result, 32'd0);
    chk({p, "_tag"}, 32'(exe_tag), 32'd0);
    chk({p, "_ready"}, 32'(id_ready), 32'd1);
    chk({p, "_perf_ops"}, perf_ops, 32'd0);
    chk({p, "_perf_stall"}, perf_stall, 32'd0);
  endtask

  initial begin
    resetn = 1'b0; id_valid = 1'b0; id_alu_op = '0; id_src1 = '0; id_src2 = '0;
    id_tag = '0; mem_ready = 1'b1; flush = 1'b0; lat_bit = 1'b0;
    held = 0; draining = 0; drain_op = '0; last_s1 = '0; last_s2 = '0;
    m_ops = 0; m_stall = 0;
    repeat (2) begin sample(); nxt(); end
    resetn = 1'b1;
    sample(); check_reset_vals("rst"); nxt();

    // Back-to-back single-cycle ADDs.
    set_op(OP_ADD, 1, 2, 5'd1); sample(); chk("add_rdy0", 32'(id_ready), 1); nxt();
    set_op(OP_ADD, 3, 4, 5'd2); sample();
    chk("add_v1", 32'(exe_valid), 1); chk("add_r1", exe_result, 3); chk("add_rdy1", 32'(id_ready), 1); nxt();
    set_op(OP_ADD, 5, 6, 5'd3); sample();
    chk("add_v2", 32'(exe_valid), 1); chk("add_r2", exe_result, 7); chk("add_rdy2", 32'(id_ready), 1); nxt();
    id_valid = 1'b0; sample();
    chk("add_v3", 32'(exe_valid), 1); chk("add_r3", exe_result, 11); chk("add_rdy3", 32'(id_ready), 1); nxt();
    sample(); chk("add_done", 32'(exe_valid), 0); nxt();

    // Long-latency DIV completing in its 34th cycle.
    do_reset();
    lat_bit = 1'b0; set_op(OP_DIV, 32'h15, 32'd3, 5'd9); sample(); nxt();
    id_valid = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      sample(); chk("div_op", 32'(alu_op), 32'(1 << OP_DIV)); chk("div_nv", 32'(exe_valid), 0); nxt();
    end
    lat_bit = 1'b1; sample();
    chk("div_op34", 32'(alu_op), 32'(1 << OP_DIV)); chk("div_v", 32'(exe_valid), 1);
    chk("div_res", exe_result, 7); chk("div_tag", 32'(exe_tag), 9); nxt();
    lat_bit = 1'b0; sample();
    chk("div_stall", perf_stall, perf_exp(33)); chk("div_ops", perf_ops, perf_exp(1));
    chk("div_idle_op", 32'(alu_op), 0); nxt();

    // MUL result held under downstream backpressure.
    set_op(OP_MUL, 32'd1234, 32'd5678, 5'd4); mem_ready = 1'b0; lat_bit = 1'b1; sample(); nxt();
    id_valid = 1'b0; sample();
    chk("mul_v", 32'(exe_valid), 1); chk("mul_r", exe_result, 32'd7006652); chk("mul_rdy", 32'(id_ready), 0); nxt();
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("hold_op", 32'(alu_op), 0); chk("hold_v", 32'(exe_valid), 1);
      chk("hold_r", exe_result, 32'd7006652); chk("hold_rdy", 32'(id_ready), 0); nxt();
    end
    mem_ready = 1'b1; sample();
    chk("hold_ret_v", 32'(exe_valid), 1); chk("hold_ret_rdy", 32'(id_ready), 1); nxt();
    sample(); chk("hold_after", 32'(exe_valid), 0); nxt();

    // Flush in the 5th busy cycle of a DIVU drains it.
    lat_bit = 1'b0; set_op(OP_DIVU, 32'd100, 32'd7, 5'd6); sample(); nxt();
    id_valid = 1'b0;
    repeat (4) begin sample(); nxt(); end
    flush = 1'b1; sample(); chk("fl_v", 32'(exe_valid), 0); chk("fl_rdy", 32'(id_ready), 0); nxt();
    flush = 1'b0; set_op(OP_ADD, 32'd8, 32'd9, 5'd7);
    repeat (3) begin
      sample(); chk("drn_op", 32'(alu_op), 32'(1 << OP_DIVU));
      chk("drn_v", 32'(exe_valid), 0); chk("drn_rdy", 32'(id_ready), 0); nxt();
    end
    flush = 1'b1; sample(); chk("drn_fl_rdy", 32'(id_ready), 0); nxt();
    flush = 1'b0; lat_bit = 1'b1; sample();
    chk("drn_cmp_op", 32'(alu_op), 32'(1 << OP_DIVU)); chk("drn_cmp_rdy", 32'(id_ready), 0);
    chk("drn_cmp_v", 32'(exe_valid), 0); nxt();
    lat_bit = 1'b0; sample(); chk("drn_done_rdy", 32'(id_ready), 1); nxt();
    id_valid = 1'b0; sample(); chk("post_v", 32'(exe_valid), 1); chk("post_r", exe_result, 17);
    chk("post_tag", 32'(exe_tag), 7); nxt();

    // Reset while draining.
    lat_bit = 1'b0; set_op(OP_DIV, 32'd50, 32'd5, 5'd3); sample(); nxt();
    id_valid = 1'b0; sample(); nxt();
    flush = 1'b1; sample(); nxt();
    flush = 1'b0; sample(); chk("rd_in_drain", 32'(alu_op), 32'(1 << OP_DIV)); nxt();
    resetn = 1'b0; sample(); nxt(); resetn = 1'b1;
    sample(); check_reset_vals("rd"); nxt();

    // Reset while holding a result.
    set_op(OP_MUL, 32'd3, 32'd5, 5'd2); mem_ready = 1'b0; lat_bit = 1'b1; sample(); nxt();
    id_valid = 1'b0; sample(); nxt();
    sample(); chk("rh_v", 32'(exe_valid), 1); chk("rh_r", exe_result, 15); nxt();
    resetn = 1'b0; sample(); nxt(); resetn = 1'b1; mem_ready = 1'b1; lat_bit = 1'b0;
    sample(); check_reset_vals("rh"); nxt();

    // Flush and id_valid together in IDLE.
    set_op(OP_ADD, 1, 1, 5'd1); flush = 1'b1; sample();
    chk("fi_rdy", 32'(id_ready), 0); chk("fi_v", 32'(exe_valid), 0); nxt();
    flush = 1'b0; id_valid = 1'b0; sample();
    chk("fi_op", 32'(alu_op), 0); chk("fi_v2", 32'(exe_valid), 0); chk("fi_ops", perf_ops, perf_exp(0)); nxt();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      id_valid  = ($urandom_range(0, 3) != 0);
      id_alu_op = ALU_OP_W'(1) << $urandom_range(0, 18);
      id_src1   = $urandom;
      id_src2   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      id_tag    = 5'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      lat_bit   = ($urandom_range(0, 2) == 0);
      resetn    = ($urandom_range(0, 299) != 0);
      sample(); nxt();
    end
    resetn = 1'b1; id_valid = 1'b0; flush = 1'b0; mem_ready = 1'b1; lat_bit = 1'b1;
    repeat (4) begin sample(); nxt(); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
